// File: rtl/spm_ctrl.sv
// -----------------------------------------------------------------------------
// spm_ctrl -- sequencer for a serial/parallel multiplier (spm) array.
//
// The array takes a parallel multiplicand on spm_x and a serial multiplier
// bit per cycle on spm_y, and returns product bits LSB first on spm_p, PLAT
// cycles after the matching y bit. This block clears the array, streams the
// sign-extended multiplier through it and gathers the 2*WIDTH product bits.
//
// Ports
//   clk        : clock, all state changes on its rising edge
//   rst        : synchronous active-high reset
//   start      : multiply request, accepted in IDLE or DONE only
//   mc, mp     : two's-complement multiplicand / multiplier, sampled on accept
//   busy       : high in CLEAR and RUN
//   done       : one-cycle pulse in DONE
//   prod       : signed product, valid with done, held until the next accept
//   spm_rst    : clear for the array registers (CLEAR state and reset cycle)
//   spm_x      : parallel operand to the array, constant through RUN
//   spm_y      : serial multiplier bit to the array
//   spm_p      : serial product bit from the array, LSB first
//   state_dbg  : current FSM state (IDLE=0, CLEAR=1, RUN=2, DONE=3)
//
// Handshake: start is a level sampled at the rising edge; it is acted on only
// when the FSM is in IDLE or DONE, otherwise it is dropped (never queued).
// done is a single-cycle qualifier for prod; there is no backpressure.
// -----------------------------------------------------------------------------
module spm_ctrl #(
   parameter int WIDTH = 32,
   parameter int PLAT  = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [WIDTH-1:0]   mc,
   input  logic [WIDTH-1:0]   mp,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] prod,
   output logic               spm_rst,
   output logic [WIDTH-1:0]   spm_x,
   output logic               spm_y,
   input  logic               spm_p,
   output logic [1:0]         state_dbg
);

   localparam int RUN_LEN = 2*WIDTH + PLAT;
   // Wide enough to hold RUN_LEN itself, so the counter can never wrap.
   localparam int CW = $clog2(RUN_LEN + 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_CLEAR = 2'd1;
   localparam logic [1:0] S_RUN   = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic [CW-1:0] CNT_LAST  = CW'(RUN_LEN - 1);
   localparam logic [CW-1:0] CAP_FIRST = CW'(PLAT);
   localparam logic [CW-1:0] Y_END     = CW'(2*WIDTH);

   logic [1:0]       state_q;
   logic [1:0]       state_d;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] mp_sr;
   logic             accept;

   assign accept = start && ((state_q == S_IDLE) || (state_q == S_DONE));

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_CLEAR;
         S_CLEAR: state_d = S_RUN;
         S_RUN:   if (cnt_q == CNT_LAST) state_d = S_DONE;
         S_DONE:  state_d = start ? S_CLEAR : S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         mp_sr   <= '0;
         spm_x   <= '0;
         prod    <= '0;
      end else begin
         state_q <= state_d;

         if ((state_q == S_RUN) && (cnt_q != CNT_LAST))
            cnt_q <= cnt_q + CW'(1);
         else
            cnt_q <= '0;

         if (state_q == S_RUN) begin
            // Arithmetic shift: once the WIDTH real bits are used up, bit 0
            // keeps presenting the sign bit, which is the sign extension.
            mp_sr <= {mp_sr[WIDTH-1], mp_sr[WIDTH-1:1]};
            // Product bits arrive PLAT cycles after their y bit; shifting in
            // at the MSB leaves the first captured bit in prod[0].
            if (cnt_q >= CAP_FIRST)
               prod <= {spm_p, prod[2*WIDTH-1:1]};
         end

         if (accept) begin
            spm_x <= mc;
            mp_sr <= mp;
            prod  <= '0;
         end
      end
   end

   // y is zero outside RUN and after the 2*WIDTH sign-extended bits, so the
   // array sees no stray partial products while the pipeline drains.
   assign spm_y     = (state_q == S_RUN) && (cnt_q < Y_END) && mp_sr[0];
   assign spm_rst   = rst || (state_q == S_CLEAR);
   assign busy      = (state_q == S_CLEAR) || (state_q == S_RUN);
   assign done      = (state_q == S_DONE);
   assign state_dbg = state_q;

endmodule

// File: tb/tb_spm_ctrl.sv
// -----------------------------------------------------------------------------
// tb_spm_ctrl -- bench for spm_ctrl with PLAT=1 and PLAT=2 instances sharing
// one stimulus stream. Each instance is paired with a behavioural spm array:
// it accumulates x * y_k * 2^k and emits bit k of the running sum, delayed by
// PLAT cycles. Products are compared with a signed product computed directly.
// -----------------------------------------------------------------------------
module tb_spm_ctrl;

   localparam int W = 32;

   logic           clk = 1'b0;
   logic           rst;
   logic           start;
   logic [W-1:0]   mc;
   logic [W-1:0]   mp;

   logic           busy_a    [2];
   logic           done_a    [2];
   logic [2*W-1:0] prod_a    [2];
   logic           spm_rst_a [2];
   logic [W-1:0]   spm_x_a   [2];
   logic           spm_y_a   [2];
   logic           spm_p_a   [2];
   logic [1:0]     state_a   [2];

   int n_vec = 0;
   int n_err = 0;

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- DUTs + array models ----------------
   for (genvar g = 0; g < 2; g++) begin : lane
      localparam int P = g + 1;
      logic [2*W-1:0] acc;
      logic [2*W-1:0] sx;
      logic [2*W-1:0] tmp;
      int             k;
      logic [P-1:0]   dly;

      spm_ctrl #(.WIDTH(W), .PLAT(P)) dut (
         .clk       (clk),
         .rst       (rst),
         .start     (start),
         .mc        (mc),
         .mp        (mp),
         .busy      (busy_a[g]),
         .done      (done_a[g]),
         .prod      (prod_a[g]),
         .spm_rst   (spm_rst_a[g]),
         .spm_x     (spm_x_a[g]),
         .spm_y     (spm_y_a[g]),
         .spm_p     (spm_p_a[g]),
         .state_dbg (state_a[g])
      );

      // Bit k of the sum is final once y_k has been added: later terms only
      // touch bits above k.
      always @(posedge clk) begin
         if (spm_rst_a[g]) begin
            acc = '0;
            k   = 0;
            dly = '0;
         end else begin
            sx = {{W{spm_x_a[g][W-1]}}, spm_x_a[g]};
            if (spm_y_a[g]) acc = acc + (sx << k);
            tmp = acc >> k;
            k   = k + 1;
            dly = P'({dly, tmp[0]});
         end
         spm_p_a[g] <= dly[P-1];
      end
   end

   // ---------------- scoreboard ----------------
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [2*W-1:0] sa;
      logic [2*W-1:0] sb;
      sa = {{W{a[W-1]}}, a};
      sb = {{W{b[W-1]}}, b};
      return sa * sb;
   endfunction

   function automatic logic [W-1:0] pick_operand();
      case ($urandom_range(0, 5))
         0:       return '0;
         1:       return '1;
         2:       return {1'b1, {(W-1){1'b0}}};
         3:       return {1'b0, {(W-1){1'b1}}};
         default: return W'($urandom);
      endcase
   endfunction

   // ---------------- driver ----------------
   // One multiply through both lanes, with a start pulse injected mid-run.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [2*W-1:0] exp_p;
      logic [2*W-1:0] p_at[2];
      int             lat[2];
      int             bcnt[2];
      bit             seen[2];
      int             n;
      exp_p = ref_prod(a, b);
      @(negedge clk);
      mc = a; mp = b; start = 1'b1;
      @(negedge clk);
      start = 1'b0; mc = W'($urandom); mp = W'($urandom);
      for (int g = 0; g < 2; g++) begin
         lat[g] = -1; bcnt[g] = 0; seen[g] = 1'b0; p_at[g] = '0;
      end
      n = 1;
      while (!(seen[0] && seen[1]) && (n <= 150)) begin
         for (int g = 0; g < 2; g++) begin
            if (!seen[g]) begin
               if (busy_a[g]) bcnt[g]++;
               if (done_a[g]) begin
                  seen[g] = 1'b1; lat[g] = n; p_at[g] = prod_a[g];
               end
            end
         end
         if (n == 30) check("spm_x_hold", spm_x_a[0], a);
         if (n == 40) begin start = 1'b1; mc = W'($urandom); mp = W'($urandom); end
         if (n == 41) start = 1'b0;
         if (!(seen[0] && seen[1])) begin
            @(negedge clk);
            n++;
         end
      end
      for (int g = 0; g < 2; g++) begin
         check($sformatf("latency_p%0d", g + 1), lat[g], 2*W + g + 1 + 2);
         check($sformatf("busy_len_p%0d", g + 1), bcnt[g], 2*W + g + 1 + 1);
         check($sformatf("prod_p%0d a=%h b=%h", g + 1, a, b), p_at[g], exp_p);
      end
      // lane 0 finished one cycle earlier and must now be idle, prod held
      check("done_one_cycle", done_a[0], 1'b0);
      check("prod_held", prod_a[0], exp_p);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; start = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int n;
      int dcount;
      rst = 1'b1; start = 1'b0; mc = '0; mp = '0;
      repeat (3) @(negedge clk);

      // reset state
      for (int g = 0; g < 2; g++) begin
         check($sformatf("rst_busy%0d", g), busy_a[g], 1'b0);
         check($sformatf("rst_done%0d", g), done_a[g], 1'b0);
         check($sformatf("rst_prod%0d", g), prod_a[g], '0);
         check($sformatf("rst_spm_x%0d", g), spm_x_a[g], '0);
         check($sformatf("rst_spm_y%0d", g), spm_y_a[g], 1'b0);
         check($sformatf("rst_spm_rst%0d", g), spm_rst_a[g], 1'b1);
      end
      // reset wins over a simultaneous start
      start = 1'b1; mc = 32'd9; mp = 32'd9;
      @(negedge clk);
      check("rst_vs_start", state_a[0], 2'd0);
      rst = 1'b0; start = 1'b0;
      @(negedge clk);
      check("idle_spm_rst", spm_rst_a[0], 1'b0);
      check("idle_spm_y", spm_y_a[0], 1'b0);
      check("idle_state", state_a[0], 2'd0);

      // directed operands
      run_op(32'd3, 32'd5);
      check("basic_15", prod_a[0], 64'h0000_0000_0000_000F);
      run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF);
      check("neg1_neg1", prod_a[0], 64'h0000_0000_0000_0001);
      run_op(32'hFFFF_FFFE, 32'd3);
      check("neg2_3", prod_a[0], 64'hFFFF_FFFF_FFFF_FFFA);
      run_op(32'h8000_0000, 32'h8000_0000);
      check("min_min", prod_a[0], 64'h4000_0000_0000_0000);
      run_op(32'h8000_0000, 32'h7FFF_FFFF);
      run_op(32'h7FFF_FFFF, 32'h7FFF_FFFF);
      run_op(32'd0, 32'h1234_5678);

      // back-to-back with start held high (lane 0)
      @(negedge clk);
      mc = 32'd7; mp = 32'd9; start = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!done_a[0] && n < 150);
      check("b2b_lat1", n, 67);
      check("b2b_prod1", prod_a[0], 64'd63);
      mc = 32'd2; mp = 32'd2;
      n = 0;
      do begin
         @(negedge clk); n++;
         if (n == 10) begin mc = 32'd123; mp = 32'd77; end
         if (n == 20) check("b2b_spm_x", spm_x_a[0], 32'd2);
      end while (!done_a[0] && n < 150);
      check("b2b_lat2", n, 67);
      check("b2b_prod2", prod_a[0], 64'd4);
      start = 1'b0;
      do_reset();

      // reset in the middle of RUN (cnt=20 on lane 0)
      @(negedge clk);
      mc = 32'hDEAD_BEEF; mp = 32'h0BAD_F00D; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (21) @(negedge clk);
      check("abort_in_run", state_a[0], 2'd2);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_busy", busy_a[0], 1'b0);
      check("abort_prod", prod_a[0], '0);
      check("abort_state", state_a[0], 2'd0);
      dcount = 0;
      repeat (80) begin
         @(negedge clk);
         if (done_a[0] || done_a[1]) dcount++;
      end
      check("abort_no_done", dcount, 0);
      run_op(32'd6, 32'd7);
      check("after_abort_42", prod_a[0], 64'd42);

      // randomized operands
      for (int i = 0; i < 300; i++) run_op(pick_operand(), pick_operand());

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
